pokey_keyboard_scan: RTL and testbench

POKEY keyboard scanner: consumer of the 15 KHz keyboard tick that the clock generator core produces. It drives a 6-bit scan address onto the external key matrix and samples the return lines. A debounce state machine turns a stable key into an 8-bit key code, a one-cycle interrupt request and live key/shift status. It sits beside the clock generator and feeds the KBCODE/SKSTAT read path and the IRQ logic.

---
 rtl/pokey_keyboard_scan.sv | 155 +++++++++++++++
 tb/tb_pokey_keyboard_scan.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pokey_keyboard_scan.sv
`default_nettype none
// ============================================================================
// Module      : pokey_keyboard_scan
// Description : POKEY keyboard matrix scanner. Walks a 6-bit scan address on
//               each keyboard tick, latches the Shift/Control modifiers and
//               debounces the key return line into an 8-bit key code, a
//               one-enabled-cycle interrupt pulse and a key-held flag.
// Revision    : 1.0 - initial release
// ============================================================================
module pokey_keyboard_scan #(
    parameter logic [5:0] SHIFT_ADDR = 6'h3D,
    parameter logic [5:0] CTRL_ADDR  = 6'h3E
) (
    input  logic       clk,
    input  logic       init,
    input  logic       enn,
    input  logic       keybClk,
    input  logic       scan_en,
    input  logic       deb_en,
    input  logic       kr1_n,
    input  logic       kr2_n,
    output logic [5:0] k,
    output logic [7:0] kbcode,
    output logic       key_irq,
    output logic       key_down,
    output logic       shift_down
);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_confirm = 2'd1;
    localparam logic [1:0] c_st_held    = 2'd2;

    logic [1:0] r_state;
    logic [5:0] r_cnt;
    logic [5:0] r_cmp;
    logic [7:0] r_kbcode;
    logic       r_irq;
    logic       r_shift;
    logic       r_ctrl;

    logic [1:0] w_state_nxt;
    logic       w_step;
    logic       w_down;
    logic       w_at_cmp;
    logic       w_accept;
    logic       w_load_cmp;

    assign w_step   = enn & ~keybClk;
    assign w_down   = ~kr1_n;
    assign w_at_cmp = (r_cnt == r_cmp);

    // Debounce state register, cleared immediately by init.
    always_ff @(negedge clk or posedge init) begin
        if (init) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus the accept / compare-load strobes. In CONFIRM and
    // HELD every decision is taken only when the counter is back at cmp, so
    // the accepted address is always the current counter value.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_load_cmp  = 1'b0;
        if (w_step) begin
            if (!scan_en) begin
                w_state_nxt = c_st_idle;
            end else begin
                case (r_state)
                    c_st_idle: begin
                        if (w_down) begin
                            w_load_cmp = 1'b1;
                            if (deb_en) begin
                                w_state_nxt = c_st_confirm;
                            end else begin
                                w_accept    = 1'b1;
                                w_state_nxt = c_st_held;
                            end
                        end
                    end
                    c_st_confirm: begin
                        if (w_at_cmp) begin
                            if (w_down) begin
                                w_accept    = 1'b1;
                                w_state_nxt = c_st_held;
                            end else begin
                                w_state_nxt = c_st_idle;
                            end
                        end
                    end
                    c_st_held: begin
                        // Without debounce a still-held key is re-accepted
                        // on each pass: the release check and the fresh IDLE
                        // hit collapse into the same step.
                        if (w_at_cmp) begin
                            if (!w_down) begin
                                w_state_nxt = c_st_idle;
                            end else if (!deb_en) begin
                                w_accept = 1'b1;
                            end
                        end
                    end
                    default: w_state_nxt = c_st_idle;
                endcase
            end
        end
    end

    // Scan counter, modifier latches, compare register, key code and IRQ.
    always_ff @(negedge clk or posedge init) begin
        if (init) begin
            r_cnt    <= 6'h00;
            r_cmp    <= 6'h00;
            r_kbcode <= 8'h00;
            r_irq    <= 1'b0;
            r_shift  <= 1'b0;
            r_ctrl   <= 1'b0;
        end else begin
            if (enn) begin
                r_irq <= w_accept;
            end
            if (w_step) begin
                if (!scan_en) begin
                    r_cnt <= 6'h00;
                end else begin
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == SHIFT_ADDR) begin
                        r_shift <= ~kr2_n;
                    end
                    if (r_cnt == CTRL_ADDR) begin
                        r_ctrl <= ~kr2_n;
                    end
                    if (w_load_cmp) begin
                        r_cmp <= r_cnt;
                    end
                    // Modifiers captured before this step's latch update.
                    if (w_accept) begin
                        r_kbcode <= {r_ctrl, r_shift, r_cnt};
                    end
                end
            end
        end
    end

    assign k          = r_cnt;
    assign kbcode     = r_kbcode;
    assign key_irq    = r_irq;
    assign key_down   = (r_state == c_st_held);
    assign shift_down = r_shift;

endmodule
`default_nettype wire

// File: tb/tb_pokey_keyboard_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_pokey_keyboard_scan
// Description : Self-checking bench for pokey_keyboard_scan. A behavioural
//               key-matrix model predicts every step; accepted key codes go
//               through a scoreboard queue drained by an IRQ monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pokey_keyboard_scan;

    localparam logic [5:0] SHIFT = 6'h3D;
    localparam logic [5:0] CTRL  = 6'h3E;

    logic       clk = 1'b0;
    logic       init = 1'b1;
    logic       enn = 1'b0;
    logic       keybClk = 1'b1;
    logic       scan_en = 1'b0;
    logic       deb_en = 1'b1;
    logic       kr1_n = 1'b1;
    logic       kr2_n = 1'b1;
    logic [5:0] k;
    logic [7:0] kbcode;
    logic       key_irq;
    logic       key_down;
    logic       shift_down;

    pokey_keyboard_scan #(
        .SHIFT_ADDR (SHIFT),
        .CTRL_ADDR  (CTRL)
    ) dut (
        .clk        (clk),
        .init       (init),
        .enn        (enn),
        .keybClk    (keybClk),
        .scan_en    (scan_en),
        .deb_en     (deb_en),
        .kr1_n      (kr1_n),
        .kr2_n      (kr2_n),
        .k          (k),
        .kbcode     (kbcode),
        .key_irq    (key_irq),
        .key_down   (key_down),
        .shift_down (shift_down)
    );

    always #5 clk = ~clk;

    // Key matrix contents and reference model state.
    bit         pressed [64];
    bit         mods    [64];
    int         mk;
    int         pending;
    int         held;
    bit         m_shift;
    bit         m_ctrl;
    bit         m_irq;
    logic [7:0] m_code;
    logic [7:0] sb_q [$];
    int         checks = 0;
    int         errors = 0;
    int         irq_pulses = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mk = 0; pending = -1; held = -1;
        m_shift = 0; m_ctrl = 0; m_irq = 0; m_code = 8'h00;
    endtask

    // One falling clock edge of the scanner, described in terms of the
    // remembered candidate address and the currently held address.
    task automatic model_edge();
        bit down;
        int acc;
        if (!enn) return;
        m_irq = 0;
        if (keybClk) return;
        if (!scan_en) begin
            mk = 0; pending = -1; held = -1;
            return;
        end
        down = !kr1_n;
        acc  = -1;
        if (held >= 0) begin
            if (mk == held) begin
                if (!down) held = -1;
                else if (!deb_en) acc = mk;
            end
        end else if (pending >= 0) begin
            if (mk == pending) begin
                pending = -1;
                if (down) begin acc = mk; held = mk; end
            end
        end else if (down) begin
            if (deb_en) pending = mk;
            else begin acc = mk; held = mk; end
        end
        if (acc >= 0) begin
            m_code = {m_ctrl, m_shift, 6'(acc)};
            m_irq  = 1;
            sb_q.push_back(m_code);
        end
        if (mk == int'(SHIFT)) m_shift = !kr2_n;
        if (mk == int'(CTRL))  m_ctrl  = !kr2_n;
        mk = (mk + 1) % 64;
    endtask

    task automatic check_outs();
        check("k", 32'(k), 32'(mk));
        check("key_down", 32'(key_down), 32'(held >= 0));
        check("shift_down", 32'(shift_down), 32'(m_shift));
        check("key_irq", 32'(key_irq), 32'(m_irq));
        check("kbcode", 32'(kbcode), 32'(m_code));
    endtask

    // Drive one clock: inputs change just after the rising edge, the DUT
    // acts on the falling edge, outputs are checked after the next rise.
    task automatic cyc(input bit en, input bit kc);
        enn     = en;
        keybClk = kc;
        kr1_n   = ~pressed[mk];
        kr2_n   = ~mods[mk];
        @(negedge clk);
        model_edge();
        @(posedge clk);
        #1;
        check_outs();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0);
    endtask

    task automatic clear_matrix();
        for (int i = 0; i < 64; i++) begin pressed[i] = 0; mods[i] = 0; end
    endtask

    // Scoreboard monitor: every rising key_irq must match the next queued code.
    initial begin
        bit         prev;
        logic [7:0] exp;
        prev = 0;
        forever begin
            @(posedge clk);
            if (key_irq && !prev) begin
                irq_pulses++;
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_irq actual=%0h required=none t=%0t", kbcode, $time);
                end else begin
                    exp = sb_q.pop_front();
                    if (kbcode !== exp) begin
                        errors++;
                        $display("FAIL sb_kbcode actual=%0h required=%0h t=%0t", kbcode, exp, $time);
                    end
                end
            end
            prev = key_irq;
        end
    end

    initial begin
        int base;
        clear_matrix();
        model_reset();
        @(posedge clk);
        #1;
        check_outs();
        @(posedge clk);
        #1;
        init    = 1'b0;
        scan_en = 1'b1;
        deb_en  = 1'b1;

        // Free-running scan with nothing pressed.
        steps(70);
        check("k_after_70", 32'(k), 32'h6);
        check("no_irq_scan", 32'(irq_pulses), 32'd0);

        // Debounced press then release.
        pressed[6'h12] = 1;
        steps(200);
        check("deb_code", 32'(kbcode), 32'h12);
        check("deb_held", 32'(key_down), 32'd1);
        check("deb_pulses", 32'(irq_pulses), 32'd1);
        pressed[6'h12] = 0;
        steps(64);
        check("deb_release", 32'(key_down), 32'd0);

        // Bounce: key seen on a single pass only.
        base = irq_pulses;
        pressed[6'h05] = 1;
        steps(64);
        pressed[6'h05] = 0;
        steps(80);
        check("bounce_pulses", 32'(irq_pulses - base), 32'd0);
        check("bounce_code", 32'(kbcode), 32'h12);

        // Modifiers.
        mods[SHIFT] = 1;
        mods[CTRL]  = 1;
        pressed[6'h21] = 1;
        steps(200);
        check("mod_code", 32'(kbcode), 32'hE1);
        check("mod_shift", 32'(shift_down), 32'd1);
        clear_matrix();
        steps(64);

        // Debounce off: one accept per pass while held.
        deb_en = 1'b0;
        base = irq_pulses;
        pressed[6'h08] = 1;
        steps(192);
        check("nodeb_pulses", 32'(irq_pulses - base), 32'd3);
        check("nodeb_code", 32'(kbcode), 32'h08);
        pressed[6'h08] = 0;
        steps(64);
        deb_en = 1'b1;

        // init while a candidate key is awaiting confirmation.
        pressed[6'h30] = 1;
        steps(64);
        init = 1'b1;
        model_reset();
        #1;
        check_outs();
        check("init_code", 32'(kbcode), 32'h00);
        @(posedge clk);
        #1;
        init = 1'b0;
        pressed[6'h30] = 0;
        steps(1);
        check("init_first_step", 32'(k), 32'h1);
        steps(69);

        // scan_en dropped while a key is held.
        pressed[6'h0A] = 1;
        steps(140);
        check("hold_before_drop", 32'(key_down), 32'd1);
        scan_en = 1'b0;
        steps(5);
        check("drop_k", 32'(k), 32'h0);
        check("drop_key_down", 32'(key_down), 32'd0);
        check("drop_code", 32'(kbcode), 32'h0A);
        scan_en = 1'b1;
        clear_matrix();
        steps(64);

        // Randomized matrix activity, gaps in enn/keybClk and scan_en drops.
        for (int r = 0; r < 40; r++) begin
            deb_en = 1'($urandom_range(0, 1));
            clear_matrix();
            pressed[$urandom_range(0, 63)] = 1;
            if ($urandom_range(0, 1) == 1) pressed[$urandom_range(0, 63)] = 1;
            mods[SHIFT] = 1'($urandom_range(0, 1));
            mods[CTRL]  = 1'($urandom_range(0, 1));
            for (int c = 0; c < 300; c++) begin
                if ($urandom_range(0, 49) == 0) pressed[$urandom_range(0, 63)] ^= 1'b1;
                scan_en = ($urandom_range(0, 29) != 0);
                cyc($urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0);
            end
        end
        scan_en = 1'b1;
        clear_matrix();
        steps(4);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
